exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception/interrupt sequencer for the five-stage MIPS core. It carries per-instruction exception codes, PCs and delay-slot flags from F down to M. It presents the oldest pending exception to CP0 at the M stage. On a CP0 request or an `eret` in M, it flushes the pipeline and redirects fetch to the handler or to EPC.

## Interface
Parameters:
- `HANDLER_PC`, default 32'h0000_4180: exception/interrupt entry address.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard stall; F/D holds, bubble into D/E.
- `f_pc` in 32: PC of the instruction in F.
- `f_exc` in 5: F-detected code (AdEL on fetch), 0 = none.
- `d_exc` in 5: D-detected code (RI = 10, Syscall = 8).
- `d_is_jump` in 1: D holds a branch/jump, so F is a delay slot.
- `e_exc` in 5: E-detected code (Ov = 12, AdEL/AdES address calc).
- `m_exc` in 5: M-detected code (AdEL = 4, AdES = 5).
- `m_eret` in 1: M holds `eret`.
- `cp0_req` in 1: CP0 `Req`.
- `cp0_epc` in 32: CP0 EPC.
- `cp0_exccode` out 5: code to CP0.
- `cp0_pc` out 32: victim PC.
- `cp0_isbd` out 1: delay-slot flag to CP0.
- `cp0_exlclr` out 1: EXL clear.
- `flush_fd`, `flush_de`, `flush_em`, `flush_mw` out 1 each: stage clears.
- `redirect_valid` out 1: override next PC.
- `redirect_pc` out 32: target PC.

## Operation
- Internal stage registers D, E, M. Each holds `code[4:0]`, `pc[31:0]`, `bd`, `valid`.
- **Code merge rule:** the inherited non-zero code wins over a code newly detected in a later stage.
  - D.code ← f_exc.
  - E.code ← D.code ? D.code : d_exc.
  - M.code ← E.code ? E.code : e_exc.
  - Merged M code = M.code ? M.code : m_exc.
- **Normal advance:** D ← {f_exc, f_pc, d_is_jump, 1}; E ← D; M ← E.
- **stall:** D holds. E ← bubble {code 0, pc = D.pc, bd = D.bd, valid 0}. M ← E.
  - Bubbles carry the PC/BD of the next real instruction, so an interrupt taken on a bubble in M records the correct EPC.
- **CP0 outputs:** cp0_pc = M.pc; cp0_isbd = M.bd; cp0_exccode = merged M code.
  - The code is forced to 0 when M.valid = 0.
  - The code is also forced to 0 in state FLUSH.
- **Trap:** when cp0_req = 1 in RUN:
  - all four flushes = 1;
  - redirect_valid = 1, redirect_pc = HANDLER_PC;
  - D, E, M load bubbles with pc = HANDLER_PC, bd 0;
  - next state FLUSH.
- **Return:** when m_eret = 1, M.valid = 1, cp0_req = 0, in RUN:
  - cp0_exlclr = 1;
  - flush_fd, flush_de, flush_em = 1; flush_mw = 0, so `eret` retires;
  - redirect to cp0_epc;
  - D, E, M load bubbles with pc = cp0_epc;
  - next state FLUSH.
- **FSM:**
  - RUN → FLUSH on trap or return.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, stall, m_eret and all exc inputs are ignored, because every stage holds a bubble.
  - cp0_req in FLUSH is still serviced as a trap, for an interrupt arriving during the flush.
- **Priority:** cp0_req > m_eret > stall.

## Timing
- **Reset:**
  - state RUN;
  - all stage registers valid 0, code 0, pc = 0, bd 0;
  - every output 0, except cp0_pc = 0 and redirect_pc = 0.
- Flush, redirect and exlclr are combinational in the same cycle as cp0_req or m_eret. The stage-register effects appear at the next edge.
- Exception latency: a code detected in F reaches CP0 exactly 3 unstalled cycles later.
- reset overrides everything, including a simultaneous cp0_req.
- A stall asserted in the same cycle as a trap is ignored.

## Structure
- A shared package holds the ExcCode constants (NONE 0, INT 0, ADEL 4, ADES 5, SYSCALL 8, RI 10, OV 12), HANDLER_PC, and the FSM state encoding.
- One sub-module, `exc_stage_reg`: holds the code/pc/bd/valid fields, with load, hold and bubble-insert controls. It is instantiated three times.

## Test plan
- **Fetch exception:** f_exc = 4 at f_pc = 0x3004, no stall.
  - 3 cycles later: cp0_exccode = 4, cp0_pc = 0x3004.
  - cp0_req = 1 → redirect_pc = 0x4180 and all flushes = 1 that cycle.
- **Merge rule:** D.code = 10 and e_exc = 12 for the same instruction → M reports 10.
- **Delay slot:** d_is_jump = 1 while f_pc = 0x3010 and e_exc = 12 for that instruction → cp0_isbd = 1, cp0_pc = 0x3010.
- **Bubble interrupt:** stall for 2 cycles while D.pc = 0x3020; cp0_req = 1 when M holds a bubble → cp0_pc = 0x3020, cp0_exccode = 0.
- **Return:** m_eret with cp0_epc = 0x3040.
  - cp0_exlclr = 1, redirect_pc = 0x3040, flush_mw = 0.
  - Next cycle: state FLUSH, and a simultaneous e_exc = 12 is ignored.
- **Reset priority:** assert reset together with cp0_req in mid-stream → next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer.
//   - MIPS ExcCode values that the pipeline stages report.
//   - The default handler entry PC.
//   - The sequencer FSM state encoding.
//   - The code-merge helper: an older, inherited exception masks a newer one.
package exc_sequencer_pkg;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // A code carried from an earlier stage belongs to an earlier event of the
    // same instruction, so it takes precedence over the newly detected one.
    function automatic logic [4:0] merge_code(input logic [4:0] inherited,
                                              input logic [4:0] detected);
        return (inherited != EXC_NONE) ? inherited : detected;
    endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// One stage of exception bookkeeping (code, pc, delay-slot flag, valid).
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears all fields)
//   load            - capture in_code/in_pc/in_bd/in_valid
//   bubble          - capture in_pc/in_bd with code 0 and valid 0 (wins over load)
//   in_*            - next-value inputs
//   code/pc/bd/valid - registered fields
// With neither load nor bubble the stage holds its contents.
module exc_stage_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [4:0]  in_code,
    input  logic [31:0] in_pc,
    input  logic        in_bd,
    input  logic        in_valid,
    output logic [4:0]  code,
    output logic [31:0] pc,
    output logic        bd,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            code  <= 5'd0;
            pc    <= 32'd0;
            bd    <= 1'b0;
            valid <= 1'b0;
        end else if (bubble) begin
            // A bubble still carries a PC so an interrupt taken on it gets a sane EPC.
            code  <= 5'd0;
            pc    <= in_pc;
            bd    <= in_bd;
            valid <= 1'b0;
        end else if (load) begin
            code  <= in_code;
            pc    <= in_pc;
            bd    <= in_bd;
            valid <= in_valid;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer for the five-stage MIPS core.
// Carries exception code, PC and delay-slot flag for each instruction from F
// to M, presents the oldest pending exception to CP0 in M, and on a CP0
// request (trap) or an eret in M (return) flushes the pipe and redirects fetch.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   stall                       - hazard stall: D holds, bubble into E
//   f_pc, f_exc                 - PC and fetch exception of the F instruction
//   d_exc, d_is_jump            - D-detected code; D holds a jump (F is a delay slot)
//   e_exc, m_exc                - E- and M-detected codes
//   m_eret                      - M holds eret
//   cp0_req, cp0_epc            - CP0 trap request and EPC
//   cp0_exccode/pc/isbd         - exception report for the M instruction
//   cp0_exlclr                  - clear EXL on eret
//   flush_fd/de/em/mw           - pipeline register clears
//   redirect_valid, redirect_pc - next-PC override
module exc_sequencer #(
    parameter logic [31:0] HANDLER_PC = exc_sequencer_pkg::HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] f_pc,
    input  logic [4:0]  f_exc,
    input  logic [4:0]  d_exc,
    input  logic        d_is_jump,
    input  logic [4:0]  e_exc,
    input  logic [4:0]  m_exc,
    input  logic        m_eret,
    input  logic        cp0_req,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_pc,
    output logic        cp0_isbd,
    output logic        cp0_exlclr,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        flush_em,
    output logic        flush_mw,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    import exc_sequencer_pkg::*;

    state_t state_q, state_d;

    // Stage fields: _p0 = D, _p1 = E, _p2 = M.
    logic [4:0]  code_p0, code_p1, code_p2;
    logic [31:0] pc_p0, pc_p1, pc_p2;
    logic        bd_p0, bd_p1, bd_p2;
    logic        vld_p0, vld_p1, vld_p2;

    logic        d_load, d_bubble, d_bd, d_valid;
    logic        e_load, e_bubble, e_bd, e_valid;
    logic        m_load, m_bubble, m_bd, m_valid;
    logic [4:0]  d_code, e_code, m_code;
    logic [31:0] d_pc, e_pc, m_pc;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        flush_fd       = 1'b0;
        flush_de       = 1'b0;
        flush_em       = 1'b0;
        flush_mw       = 1'b0;
        cp0_exlclr     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Normal advance with the code-merge rule applied at each boundary.
        d_load = 1'b1; d_bubble = 1'b0;
        d_code = f_exc; d_pc = f_pc; d_bd = d_is_jump; d_valid = 1'b1;
        e_load = 1'b1; e_bubble = 1'b0;
        e_code = merge_code(code_p0, d_exc); e_pc = pc_p0; e_bd = bd_p0; e_valid = vld_p0;
        m_load = 1'b1; m_bubble = 1'b0;
        m_code = merge_code(code_p1, e_exc); m_pc = pc_p1; m_bd = bd_p1; m_valid = vld_p1;

        if (reset) begin
            // Reset wins over everything; stage registers clear themselves.
        end else if (cp0_req) begin
            // Trap: serviced in RUN and in FLUSH (late interrupt).
            flush_fd = 1'b1; flush_de = 1'b1; flush_em = 1'b1; flush_mw = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = HANDLER_PC;
            d_bubble = 1'b1; d_pc = HANDLER_PC; d_bd = 1'b0;
            e_bubble = 1'b1; e_pc = HANDLER_PC; e_bd = 1'b0;
            m_bubble = 1'b1; m_pc = HANDLER_PC; m_bd = 1'b0;
            state_d  = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            // Every stage holds a bubble, so stall, eret and detected codes are
            // meaningless this cycle; only the refetched F instruction enters D.
            d_code  = EXC_NONE;
            d_bd    = 1'b0;
            e_code  = code_p0;
            m_code  = code_p1;
            state_d = ST_RUN;
        end else if (m_eret && vld_p2) begin
            // Return: eret itself retires, so M/W is not flushed.
            cp0_exlclr = 1'b1;
            flush_fd = 1'b1; flush_de = 1'b1; flush_em = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = cp0_epc;
            d_bubble = 1'b1; d_pc = cp0_epc; d_bd = 1'b0;
            e_bubble = 1'b1; e_pc = cp0_epc; e_bd = 1'b0;
            m_bubble = 1'b1; m_pc = cp0_epc; m_bd = 1'b0;
            state_d  = ST_FLUSH;
        end else if (stall) begin
            // D holds; E takes a bubble tagged with D's PC/BD.
            d_load   = 1'b0;
            e_bubble = 1'b1;
        end
    end

    // ---- F -> D boundary ----
    exc_stage_reg u_stage_d (
        .clk(clk), .reset(reset), .load(d_load), .bubble(d_bubble),
        .in_code(d_code), .in_pc(d_pc), .in_bd(d_bd), .in_valid(d_valid),
        .code(code_p0), .pc(pc_p0), .bd(bd_p0), .valid(vld_p0)
    );

    // ---- D -> E boundary ----
    exc_stage_reg u_stage_e (
        .clk(clk), .reset(reset), .load(e_load), .bubble(e_bubble),
        .in_code(e_code), .in_pc(e_pc), .in_bd(e_bd), .in_valid(e_valid),
        .code(code_p1), .pc(pc_p1), .bd(bd_p1), .valid(vld_p1)
    );

    // ---- E -> M boundary ----
    exc_stage_reg u_stage_m (
        .clk(clk), .reset(reset), .load(m_load), .bubble(m_bubble),
        .in_code(m_code), .in_pc(m_pc), .in_bd(m_bd), .in_valid(m_valid),
        .code(code_p2), .pc(pc_p2), .bd(bd_p2), .valid(vld_p2)
    );

    // ---- M -> CP0 ----
    assign cp0_pc      = pc_p2;
    assign cp0_isbd    = bd_p2;
    assign cp0_exccode = (state_q == ST_RUN && vld_p2) ? merge_code(code_p2, m_exc) : EXC_NONE;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: fetch exception and trap, merge rule,
// delay slot, interrupt on a bubble, eret return, and reset priority.
module tb_exc_sequencer;
    import exc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, d_is_jump, m_eret, cp0_req;
    logic [31:0] f_pc, cp0_epc;
    logic [4:0]  f_exc, d_exc, e_exc, m_exc;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_pc, redirect_pc;
    logic        cp0_isbd, cp0_exlclr, flush_fd, flush_de, flush_em, flush_mw, redirect_valid;

    int n_checks = 0;
    int n_pass   = 0;

    exc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .f_pc(f_pc), .f_exc(f_exc),
        .d_exc(d_exc), .d_is_jump(d_is_jump), .e_exc(e_exc), .m_exc(m_exc),
        .m_eret(m_eret), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
        .cp0_exccode(cp0_exccode), .cp0_pc(cp0_pc), .cp0_isbd(cp0_isbd),
        .cp0_exlclr(cp0_exlclr), .flush_fd(flush_fd), .flush_de(flush_de),
        .flush_em(flush_em), .flush_mw(flush_mw),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; d_is_jump = 0; m_eret = 0; cp0_req = 0;
        f_exc = 0; d_exc = 0; e_exc = 0; m_exc = 0; cp0_epc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        f_pc = 32'h0000_1234;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        n_checks++;
        if ({cp0_exccode, cp0_isbd, cp0_exlclr, flush_fd, flush_de, flush_em, flush_mw, redirect_valid} !== 12'd0)
            $display("FAIL reset_ctrl: got %h expected 0",
                     {cp0_exccode, cp0_isbd, cp0_exlclr, flush_fd, flush_de, flush_em, flush_mw, redirect_valid});
        else n_pass++;
        n_checks++;
        if (cp0_pc !== 32'd0 || redirect_pc !== 32'd0)
            $display("FAIL reset_pcs: got cp0_pc=%h redirect_pc=%h expected 0", cp0_pc, redirect_pc);
        else n_pass++;
    endtask

    task automatic test_fetch_exc();
        f_pc = 32'h3004; f_exc = 5'd4;
        tick();
        f_exc = 0; f_pc = 32'h3008;
        tick();
        f_pc = 32'h300c;
        tick();
        #1;
        n_checks++;
        if (cp0_exccode !== 5'd4 || cp0_pc !== 32'h3004)
            $display("FAIL fetch_exc: got code=%0d pc=%h expected 4/00003004", cp0_exccode, cp0_pc);
        else n_pass++;
        n_checks++;
        if ({flush_fd, flush_de, flush_em, flush_mw, redirect_valid} !== 5'b00000)
            $display("FAIL fetch_noflush: got %b expected 00000",
                     {flush_fd, flush_de, flush_em, flush_mw, redirect_valid});
        else n_pass++;
        cp0_req = 1;
        #1;
        n_checks++;
        if ({flush_fd, flush_de, flush_em, flush_mw, redirect_valid} !== 5'b11111 || redirect_pc !== 32'h4180)
            $display("FAIL trap_redirect: got flags=%b pc=%h expected 11111/00004180",
                     {flush_fd, flush_de, flush_em, flush_mw, redirect_valid}, redirect_pc);
        else n_pass++;
        tick();
        cp0_req = 0; f_pc = 32'h4180;
        #1;
        n_checks++;
        if (dut.state_q !== ST_FLUSH || cp0_exccode !== 5'd0 || cp0_pc !== 32'h4180)
            $display("FAIL trap_flush_state: got st=%0d code=%0d pc=%h expected 1/0/00004180",
                     dut.state_q, cp0_exccode, cp0_pc);
        else n_pass++;
        tick();
    endtask

    task automatic test_merge();
        f_pc = 32'h3100;
        tick();
        f_pc = 32'h3104; d_exc = 5'd10;
        tick();
        d_exc = 0; e_exc = 5'd12; f_pc = 32'h3108;
        tick();
        e_exc = 0;
        #1;
        n_checks++;
        if (cp0_exccode !== 5'd10 || cp0_pc !== 32'h3100)
            $display("FAIL merge: got code=%0d pc=%h expected 10/00003100", cp0_exccode, cp0_pc);
        else n_pass++;
        // M stage with no inherited code reports the M-detected one.
        tick();
        m_exc = 5'd5;
        #1;
        n_checks++;
        if (cp0_exccode !== 5'd5 || cp0_pc !== 32'h3104)
            $display("FAIL merge_m: got code=%0d pc=%h expected 5/00003104", cp0_exccode, cp0_pc);
        else n_pass++;
        m_exc = 0;
    endtask

    task automatic test_delay_slot();
        f_pc = 32'h300c; d_is_jump = 0;
        tick();
        f_pc = 32'h3010; d_is_jump = 1;
        tick();
        f_pc = 32'h3014; d_is_jump = 0;
        tick();
        e_exc = 5'd12; f_pc = 32'h3018;
        tick();
        e_exc = 0;
        #1;
        n_checks++;
        if (cp0_exccode !== 5'd12 || cp0_isbd !== 1'b1 || cp0_pc !== 32'h3010)
            $display("FAIL delay_slot: got code=%0d bd=%b pc=%h expected 12/1/00003010",
                     cp0_exccode, cp0_isbd, cp0_pc);
        else n_pass++;
    endtask

    task automatic test_bubble_interrupt();
        f_pc = 32'h3020;
        tick();
        f_pc = 32'h3024; stall = 1;
        tick();
        tick();
        stall = 0; cp0_req = 1;
        #1;
        n_checks++;
        if (cp0_pc !== 32'h3020 || cp0_exccode !== 5'd0 || redirect_valid !== 1'b1)
            $display("FAIL bubble_int: got pc=%h code=%0d rv=%b expected 00003020/0/1",
                     cp0_pc, cp0_exccode, redirect_valid);
        else n_pass++;
        // A stall coincident with the trap must not keep D holding 0x3020.
        stall = 1;
        tick();
        stall = 0; cp0_req = 0; f_pc = 32'h4180;
        #1;
        n_checks++;
        if (dut.state_q !== ST_FLUSH || dut.pc_p0 !== 32'h4180)
            $display("FAIL trap_over_stall: got st=%0d dpc=%h expected 1/00004180", dut.state_q, dut.pc_p0);
        else n_pass++;
        tick();
    endtask

    task automatic test_return();
        f_pc = 32'h3030;
        tick(); tick(); tick();
        m_eret = 1; cp0_epc = 32'h3040;
        #1;
        n_checks++;
        if (cp0_exlclr !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h3040)
            $display("FAIL eret_redirect: got exl=%b rv=%b pc=%h expected 1/1/00003040",
                     cp0_exlclr, redirect_valid, redirect_pc);
        else n_pass++;
        n_checks++;
        if ({flush_fd, flush_de, flush_em, flush_mw} !== 4'b1110)
            $display("FAIL eret_flush: got %b expected 1110", {flush_fd, flush_de, flush_em, flush_mw});
        else n_pass++;
        tick();
        e_exc = 5'd12; f_pc = 32'h3040;
        #1;
        n_checks++;
        if (dut.state_q !== ST_FLUSH || cp0_exlclr !== 1'b0 || redirect_valid !== 1'b0 || cp0_exccode !== 5'd0)
            $display("FAIL eret_flush_state: got st=%0d exl=%b rv=%b code=%0d expected 1/0/0/0",
                     dut.state_q, cp0_exlclr, redirect_valid, cp0_exccode);
        else n_pass++;
        tick();
        e_exc = 0; m_eret = 0;
        #1;
        n_checks++;
        if (dut.state_q !== ST_RUN || dut.code_p2 !== 5'd0 || cp0_pc !== 32'h3040)
            $display("FAIL flush_ignores_exc: got st=%0d mcode=%0d pc=%h expected 0/0/00003040",
                     dut.state_q, dut.code_p2, cp0_pc);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        f_pc = 32'h3050; f_exc = 5'd4;
        tick(); tick();
        f_exc = 0;
        tick();
        reset = 1; cp0_req = 1;
        tick();
        reset = 0; cp0_req = 0;
        #1;
        n_checks++;
        if ({cp0_exccode, cp0_isbd, cp0_exlclr, flush_fd, flush_de, flush_em, flush_mw, redirect_valid} !== 12'd0
            || cp0_pc !== 32'd0 || redirect_pc !== 32'd0)
            $display("FAIL reset_prio_out: got code=%0d pc=%h rpc=%h rv=%b expected all 0",
                     cp0_exccode, cp0_pc, redirect_pc, redirect_valid);
        else n_pass++;
        n_checks++;
        if (dut.state_q !== ST_RUN)
            $display("FAIL reset_prio_state: got %0d expected 0", dut.state_q);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch_exc();
        test_merge();
        test_delay_slot();
        test_bubble_interrupt();
        test_return();
        test_reset_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
